// File: rtl/uart_char_rx.sv
// 8N1 serial receiver: 2-FF synchronised rx, run-time bit period, mid-bit sampling,
// single-entry valid/ready output with framing-error and overrun pulses.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronised line
// START | counting to mid start bit; confirms start or rejects a glitch
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit; high completes the byte, low is a framing error
module uart_char_rx #(
   parameter int unsigned MIN_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic [15:0] freq,
   input  logic        char_ready,
   output logic [7:0]  char,
   output logic        char_valid,
   output logic        frame_err,
   output logic        overrun,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_nxt;
   logic        rx_meta, rs, rs_prev;
   logic [15:0] div, div_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [2:0]  bitidx, bitidx_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        done_q, done_nxt;
   logic        fe_nxt;
   logic        fall;
   logic [15:0] freq_clamped;
   logic [15:0] half_m1;
   logic [15:0] div_m1;

   assign fall         = rs_prev & ~rs;
   assign freq_clamped = (freq < 16'(MIN_DIV)) ? 16'(MIN_DIV) : freq;
   assign half_m1      = (div >> 1) - 16'd1;
   assign div_m1       = div - 16'd1;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rs      <= 1'b1;
         rs_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;
         rs_prev <= rs;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         div       <= 16'(MIN_DIV);
         cnt       <= 16'd0;
         bitidx    <= 3'd0;
         shift     <= 8'h00;
         done_q    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         div       <= div_nxt;
         cnt       <= cnt_nxt;
         bitidx    <= bitidx_nxt;
         shift     <= shift_nxt;
         done_q    <= done_nxt;
         frame_err <= fe_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      div_nxt    = div;
      cnt_nxt    = cnt;
      bitidx_nxt = bitidx;
      shift_nxt  = shift;
      done_nxt   = 1'b0;
      fe_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               div_nxt   = freq_clamped;
               cnt_nxt   = 16'd0;
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == half_m1) begin
               cnt_nxt = 16'd0;
               if (!rs) begin
                  bitidx_nxt = 3'd0;
                  state_nxt  = DATA;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         DATA: begin
            if (cnt == div_m1) begin
               shift_nxt[bitidx] = rs;
               cnt_nxt           = 16'd0;
               if (bitidx == 3'd7) state_nxt  = STOP;
               else                bitidx_nxt = bitidx + 3'd1;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         STOP: begin
            if (cnt == div_m1) begin
               cnt_nxt   = 16'd0;
               state_nxt = IDLE;
               if (rs) done_nxt = 1'b1;
               else    fe_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A completed byte lands one cycle after the stop sample; an unconsumed byte wins over it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         char       <= 8'h00;
         char_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done_q) begin
            if (!char_valid || char_ready) begin
               char       <= shift;
               char_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (char_valid && char_ready) begin
            char_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_char_rx.sv
// Directed bench for uart_char_rx: frames driven bit by bit, outputs checked against
// hand-computed bytes and pulse counts.
module tb_uart_char_rx;

   logic        clk;
   logic        reset;
   logic        rx;
   logic [15:0] freq;
   logic        char_ready;
   logic [7:0]  char;
   logic        char_valid;
   logic        frame_err;
   logic        overrun;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int acc_cnt = 0;

   uart_char_rx #(.MIN_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .freq       (freq),
      .char_ready (char_ready),
      .char       (char),
      .char_valid (char_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (char_valid && char_ready) acc_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_clks);
      rx = 1'b0;
      tick(bit_clks);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(bit_clks);
      end
      rx = stop_bit;
      tick(bit_clks);
      rx = 1'b1;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (char !== 8'h00) begin errors++; $display("FAIL reset_char: got %h expected 00", char); end
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", char_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tick(3);
      reset = 1'b1;
      tick(5);
   endtask

   task automatic test_basic_rx;
      int fe0, ov0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      freq = 16'd16; char_ready = 1'b0;
      send_frame(8'h41, 1'b1, 16);
      tick(10);
      checks++; if (char !== 8'h41) begin errors++; $display("FAIL basic_char: got %h expected 41", char); end
      checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", char_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
      tick(20);
      checks++; if (char_valid !== 1'b1 || char !== 8'h41) begin errors++; $display("FAIL basic_hold: got valid=%b char=%h expected valid=1 char=41", char_valid, char); end
      checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL basic_pulses: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_cnt, ov_cnt, fe0, ov0); end
   endtask

   task automatic test_overrun;
      int ov0, acc0;
      ov0 = ov_cnt; acc0 = acc_cnt;
      send_frame(8'h5A, 1'b1, 16);
      tick(10);
      checks++; if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL overrun_count: got %0d expected %0d", ov_cnt, ov0 + 1); end
      checks++; if (char !== 8'h41) begin errors++; $display("FAIL overrun_char: got %h expected 41", char); end
      checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", char_valid); end
      char_ready = 1'b1;
      tick(1);
      char_ready = 1'b0;
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b expected 0", char_valid); end
      checks++; if (acc_cnt != acc0 + 1) begin errors++; $display("FAIL consume_count: got %0d expected %0d", acc_cnt, acc0 + 1); end
   endtask

   task automatic test_glitch;
      int fe0;
      fe0 = fe_cnt;
      freq = 16'd16;
      rx = 1'b0;
      tick(5);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
      rx = 1'b1;
      tick(20);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", char_valid); end
      checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected %0d", fe_cnt, fe0); end
   endtask

   task automatic test_frame_err;
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h33, 1'b0, 16);
      rx = 1'b0;
      tick(10);
      checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL frame_err_count: got %0d expected %0d", fe_cnt, fe0 + 1); end
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL frame_err_valid: got %b expected 0", char_valid); end
      tick(200);
      checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL break_frame_err: got %0d expected %0d", fe_cnt, fe0 + 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", busy); end
      checks++; if (char_valid !== 1'b0 || char !== 8'h41) begin errors++; $display("FAIL break_char: got valid=%b char=%h expected valid=0 char=41", char_valid, char); end
      rx = 1'b1;
      tick(20);
   endtask

   task automatic test_back_to_back;
      int fe0, ov0, acc0;
      fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
      freq = 16'd2; char_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_frame(8'hFF, 1'b1, 4);
      tick(10);
      checks++; if (acc_cnt != acc0 + 3) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", acc_cnt, acc0 + 3); end
      checks++; if (char !== 8'hFF) begin errors++; $display("FAIL b2b_char: got %h expected ff", char); end
      checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL b2b_overrun: got %0d expected %0d", ov_cnt, ov0); end
      checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected %0d", fe_cnt, fe0); end
      checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", char_valid); end
      char_ready = 1'b0;
      tick(10);
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] partial;
      int fe0, ov0;
      partial = 8'hC3;
      freq = 16'd16;
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         rx = partial[i];
         tick(16);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (char !== 8'h00 || char_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_char: got valid=%b char=%h expected valid=0 char=00", char_valid, char); end
      checks++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got busy=%b fe=%b ov=%b expected 0 0 0", busy, frame_err, overrun); end
      tick(3);
      rx = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(5);
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h7E, 1'b1, 16);
      tick(10);
      checks++; if (char !== 8'h7E || char_valid !== 1'b1) begin errors++; $display("FAIL after_reset_char: got valid=%b char=%h expected valid=1 char=7e", char_valid, char); end
      checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL after_reset_pulses: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_cnt, ov_cnt, fe0, ov0); end
   endtask

   initial begin
      reset = 1'b0;
      rx = 1'b1;
      freq = 16'd16;
      char_ready = 1'b0;
      test_reset;
      test_basic_rx;
      test_overrun;
      test_glitch;
      test_frame_err;
      test_back_to_back;
      test_reset_mid_frame;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
